// File: rtl/button_event_classifier.sv
// ----------------------------------------------------------------------------
// button_event_classifier
//
// Purpose:
//   Classifies a debounced, clock-synchronous button level into events:
//   press, release, short press, long press and auto-repeat while held.
//   A button that is already pressed when reset is released is ignored until
//   it has been seen released once (WAIT_LOW state).
//
// Ports:
//   clk_i        in   system clock, rising edge
//   rst_i        in   asynchronous active-high reset
//   db_i         in   debounced button level, 1 = pressed
//   press_o      out  one-cycle pulse on accepted press
//   release_o    out  one-cycle pulse on release of an accepted press
//   short_o      out  one-cycle pulse, released before the long threshold
//   long_o       out  one-cycle pulse, long threshold reached while held
//   repeat_o     out  one-cycle pulse every REPEAT_CYC cycles after long
//   held_o       out  level, high while the registered state is HELD
//   short_cnt_o  out  wrapping count of short presses
//   long_cnt_o   out  wrapping count of long presses
// ----------------------------------------------------------------------------
module button_event_classifier #(
  parameter int CLK_PER_TICK = 16,
  parameter int LONG_TICKS   = 8,
  parameter int REPEAT_TICKS = 4,
  parameter int CNT_W        = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             db_i,
  output logic             press_o,
  output logic             release_o,
  output logic             short_o,
  output logic             long_o,
  output logic             repeat_o,
  output logic             held_o,
  output logic [CNT_W-1:0] short_cnt_o,
  output logic [CNT_W-1:0] long_cnt_o
);

  localparam int LONG_CYC   = CLK_PER_TICK * LONG_TICKS;
  localparam int REPEAT_CYC = CLK_PER_TICK * REPEAT_TICKS;
  localparam int MAX_CYC    = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
  localparam int HOLD_W     = $clog2(MAX_CYC + 1);

  // The hold counter is cleared at the entry edge, so at the edge k cycles
  // after entry it holds k-1. Comparing against CYC-1 therefore fires at
  // exactly entry + CYC.
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYC - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYC - 1);

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    IDLE     = 2'd1,
    PRESSED  = 2'd2,
    HELD     = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               press_q, press_d;
  logic               release_q, release_d;
  logic               short_q, short_d;
  logic               long_q, long_d;
  logic               repeat_q, repeat_d;
  logic               held_q, held_d;
  logic [CNT_W-1:0]   short_cnt_q, short_cnt_d;
  logic [CNT_W-1:0]   long_cnt_q, long_cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= WAIT_LOW;
      hold_q      <= '0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      short_q     <= 1'b0;
      long_q      <= 1'b0;
      repeat_q    <= 1'b0;
      held_q      <= 1'b0;
      short_cnt_q <= '0;
      long_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      press_q     <= press_d;
      release_q   <= release_d;
      short_q     <= short_d;
      long_q      <= long_d;
      repeat_q    <= repeat_d;
      held_q      <= held_d;
      short_cnt_q <= short_cnt_d;
      long_cnt_q  <= long_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    short_d     = 1'b0;
    long_d      = 1'b0;
    repeat_d    = 1'b0;
    short_cnt_d = short_cnt_q;
    long_cnt_d  = long_cnt_q;

    case (state_q)
      WAIT_LOW: begin
        if (!db_i) begin
          state_d = IDLE;
          hold_d  = '0;
        end
      end

      IDLE: begin
        if (db_i) begin
          state_d = PRESSED;
          hold_d  = '0;
          press_d = 1'b1;
        end
      end

      PRESSED: begin
        // Release is tested first so a release on the threshold edge itself
        // is still a short press.
        if (!db_i) begin
          state_d     = IDLE;
          hold_d      = '0;
          short_d     = 1'b1;
          release_d   = 1'b1;
          short_cnt_d = short_cnt_q + CNT_W'(1);
        end else if (hold_q == LONG_LAST) begin
          state_d    = HELD;
          hold_d     = '0;
          long_d     = 1'b1;
          long_cnt_d = long_cnt_q + CNT_W'(1);
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      HELD: begin
        // Release has priority over a coincident repeat.
        if (!db_i) begin
          state_d   = IDLE;
          hold_d    = '0;
          release_d = 1'b1;
        end else if (hold_q == REP_LAST) begin
          hold_d   = '0;
          repeat_d = 1'b1;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      default: begin
        state_d = WAIT_LOW;
        hold_d  = '0;
      end
    endcase
  end

  // Registered copy of "next state is HELD" so held_o tracks state_q exactly.
  assign held_d = (state_d == HELD);

  assign press_o     = press_q;
  assign release_o   = release_q;
  assign short_o     = short_q;
  assign long_o      = long_q;
  assign repeat_o    = repeat_q;
  assign held_o      = held_q;
  assign short_cnt_o = short_cnt_q;
  assign long_cnt_o  = long_cnt_q;

endmodule

// File: tb/tb_button_event_classifier.sv
// ----------------------------------------------------------------------------
// tb_button_event_classifier
//
// Directed bench for button_event_classifier with default parameters
// (long threshold 128 cycles, repeat period 64 cycles). Expected pulse
// events are queued with the edge index after which they must appear and
// compared every cycle; counters and held_o are compared every cycle too.
// ----------------------------------------------------------------------------
module tb_button_event_classifier;

  localparam int LONG_CYC = 128;
  localparam int REP_CYC  = 64;

  // Pulse vector bit layout: {press, release, short, long, repeat}
  localparam logic [4:0] B_PRESS = 5'b10000;
  localparam logic [4:0] B_REL   = 5'b01000;
  localparam logic [4:0] B_SHORT = 5'b00100;
  localparam logic [4:0] B_LONG  = 5'b00010;
  localparam logic [4:0] B_REP   = 5'b00001;

  typedef struct {
    int         e;
    logic [4:0] v;
  } ev_t;

  logic       clk_i;
  logic       rst_i;
  logic       db_i;
  logic       press_o;
  logic       release_o;
  logic       short_o;
  logic       long_o;
  logic       repeat_o;
  logic       held_o;
  logic [7:0] short_cnt_o;
  logic [7:0] long_cnt_o;

  ev_t        sb[$];
  int         edge_idx;
  int         held_from;
  int         held_to;
  logic [7:0] exp_short;
  logic [7:0] exp_long;
  int         obs_press;
  int         obs_short;
  int         checks;
  int         errors;

  button_event_classifier dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .db_i        (db_i),
    .press_o     (press_o),
    .release_o   (release_o),
    .short_o     (short_o),
    .long_o      (long_o),
    .repeat_o    (repeat_o),
    .held_o      (held_o),
    .short_cnt_o (short_cnt_o),
    .long_cnt_o  (long_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int e, input logic [4:0] v);
    ev_t ev;
    ev.e = e;
    ev.v = v;
    sb.push_back(ev);
  endtask

  // Drive db, take one rising edge, then compare the cycle after that edge.
  task automatic tick(input logic d);
    ev_t        ev;
    logic [4:0] exp_v;
    logic [4:0] obs_v;
    db_i = d;
    @(posedge clk_i);
    edge_idx++;
    #1;
    while (sb.size() > 0 && sb[0].e < edge_idx) begin
      check("sb_order", 32'(sb[0].e), 32'(edge_idx));
      ev = sb.pop_front();
    end
    exp_v = '0;
    if (sb.size() > 0 && sb[0].e == edge_idx) begin
      ev    = sb.pop_front();
      exp_v = ev.v;
    end
    if (exp_v[2]) exp_short = exp_short + 8'd1;
    if (exp_v[1]) exp_long  = exp_long + 8'd1;
    obs_v = {press_o, release_o, short_o, long_o, repeat_o};
    check("pulses", 32'(obs_v), 32'(exp_v));
    check("held", 32'(held_o), 32'(edge_idx >= held_from && edge_idx < held_to));
    check("short_cnt", 32'(short_cnt_o), 32'(exp_short));
    check("long_cnt", 32'(long_cnt_o), 32'(exp_long));
    if (press_o) obs_press++;
    if (short_o) obs_short++;
  endtask

  // Press held for 'hold' sampled-high edges starting at E0, then one low edge.
  task automatic press_seq(input int hold);
    int e0;
    e0 = edge_idx + 1;
    push(e0, B_PRESS);
    if (hold > LONG_CYC) begin
      push(e0 + LONG_CYC, B_LONG);
      for (int r = e0 + LONG_CYC + REP_CYC; r < e0 + hold; r += REP_CYC)
        push(r, B_REP);
      push(e0 + hold, B_REL);
      held_from = e0 + LONG_CYC;
      held_to   = e0 + hold;
    end else begin
      push(e0 + hold, B_SHORT | B_REL);
    end
    repeat (hold) tick(1'b1);
    tick(1'b0);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    #2;
    rst_i = 1'b1;
    #1;
    check("rst_pulses", 32'({press_o, release_o, short_o, long_o, repeat_o}), 32'(0));
    check("rst_held", 32'(held_o), 32'(0));
    check("rst_short_cnt", 32'(short_cnt_o), 32'(0));
    check("rst_long_cnt", 32'(long_cnt_o), 32'(0));
    check("rst_sb_empty", 32'(sb.size()), 32'(0));
    sb.delete();
    exp_short = '0;
    exp_long  = '0;
    held_from = 0;
    held_to   = 0;
    #2;
    rst_i = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    edge_idx  = 0;
    held_from = 0;
    held_to   = 0;
    exp_short = '0;
    exp_long  = '0;
    obs_press = 0;
    obs_short = 0;
    rst_i     = 1'b1;
    db_i      = 1'b0;

    repeat (3) @(posedge clk_i);
    #1;
    do_reset();

    // Leave WAIT_LOW, idle a little.
    repeat (3) tick(1'b0);

    // Short press of 50 cycles.
    press_seq(50);
    repeat (3) tick(1'b0);

    // Long press of 300 cycles: long, repeats at +192 and +256, release.
    press_seq(300);
    repeat (3) tick(1'b0);

    // Release sampled exactly at the threshold edge: short, never long.
    press_seq(128);
    repeat (2) tick(1'b0);

    // Release on the same edge as a repeat: release only.
    press_seq(256);
    repeat (2) tick(1'b0);

    // Third long press, reset while held, button kept down across reset.
    begin
      int e0;
      e0 = edge_idx + 1;
      push(e0, B_PRESS);
      push(e0 + LONG_CYC, B_LONG);
      held_from = e0 + LONG_CYC;
      held_to   = 32'h7fffffff;
      repeat (140) tick(1'b1);
    end
    check("long_cnt_before_rst", 32'(long_cnt_o), 32'(3));
    check("held_before_rst", 32'(held_o), 32'(1));
    do_reset();
    // Stuck-high press after reset must be ignored, with no late release.
    repeat (10) tick(1'b1);
    tick(1'b0);
    press_seq(20);
    repeat (2) tick(1'b0);
    check("short_after_stuck", 32'(short_cnt_o), 32'(1));

    // 256 back-to-back short presses, 10 high / 1 low, counter wraps.
    do_reset();
    tick(1'b0);
    obs_press = 0;
    obs_short = 0;
    repeat (255) press_seq(10);
    check("short_cnt_255", 32'(short_cnt_o), 32'(255));
    press_seq(10);
    repeat (2) tick(1'b0);
    check("short_cnt_wrap", 32'(short_cnt_o), 32'(0));
    check("press_count", 32'(obs_press), 32'(256));
    check("short_count", 32'(obs_short), 32'(256));
    check("sb_empty", 32'(sb.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
